dm_mmio_responder: RTL and testbench

Responder for the CPU data-memory port. Word-addressed SRAM plus a small memory-mapped register block, for simulation and synthesis alongside `CPU` inside `top`. It decodes each `DM_enable` access to either the local array or the registers. It returns read data with one-cycle latency and raises `done` when the program writes TOHOST, so benches can stop without a fixed cycle count.

---
 rtl/dm_mmio_pkg.sv | 21 ++
 rtl/dm_sram.sv | 21 ++
 rtl/dm_mmio_responder.sv | 131 +++++++++++++
 tb/tb_dm_mmio_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_mmio_pkg.sv
// Shared constants and decode types for the data-memory responder.
// Address map, MMIO register offsets and STATUS bit positions.
package dm_mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

  localparam logic [1:0] REG_CYCLE  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_TOHOST = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    DEC_SRAM,
    DEC_MMIO,
    DEC_UNMAPPED
  } dec_e;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;

endpackage

// File: rtl/dm_sram.sv
// Word-addressed data SRAM with a registered read port.
// Contents are never reset so preloaded data survives.
module dm_sram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_data [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_data[addr] <= wdata;
    if (re) rdata <= mem_data[addr];
  end

endmodule

// File: rtl/dm_mmio_responder.sv
// CPU data-memory responder: SRAM plus CYCLE/CTRL/TOHOST/STATUS
// registers, one-cycle read latency, sticky done on TOHOST write.
module dm_mmio_responder
  import dm_mmio_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] BAD_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_enable,
  input  logic        DM_write,
  input  logic [31:0] DM_address,
  input  logic [31:0] DM_in,
  output logic [31:0] DM_out,
  output logic        done,
  output logic [31:0] tohost,
  output logic        err
);

  dec_e        dec;
  logic        rd;
  logic        wr;
  logic [1:0]  reg_sel;
  logic        mmio_wr;
  logic [31:0] status;
  logic [31:0] reg_rdata;
  logic [31:0] sram_rdata;
  logic [31:0] cycle;
  logic [31:0] ctrl;
  logic        err_seen;
  logic [31:0] rd_q;
  logic        sel_sram;
  logic        unused_lsb;

  assign unused_lsb = ^DM_address[1:0];

  always_comb begin
    dec = DEC_UNMAPPED;
    unique case (1'b1)
      (DM_address[31:ADDR_W+2] == '0):
        dec = DEC_SRAM;
      (DM_address[31:4] == MMIO_BASE[31:4]):
        dec = DEC_MMIO;
      default:
        dec = DEC_UNMAPPED;
    endcase
  end

  assign rd      = DM_enable & ~DM_write;
  assign wr      = DM_enable & DM_write;
  assign reg_sel = DM_address[3:2];
  assign mmio_wr = wr && (dec == DEC_MMIO);

  dm_sram #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk  (clk),
    .we   (wr && (dec == DEC_SRAM)),
    .re   (rd && (dec == DEC_SRAM)),
    .addr (DM_address[ADDR_W+1:2]),
    .wdata(DM_in),
    .rdata(sram_rdata)
  );

  always_comb begin
    status            = '0;
    status[STAT_DONE] = done;
    status[STAT_ERR]  = err_seen;
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_sel)
      REG_CYCLE:  reg_rdata = cycle;
      REG_CTRL:   reg_rdata = ctrl;
      REG_TOHOST: reg_rdata = tohost;
      REG_STATUS: reg_rdata = status;
    endcase
  end

  // A CYCLE write wins over the increment of the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle <= '0;
    end else if (mmio_wr && reg_sel == REG_CYCLE) begin
      cycle <= DM_in;
    end else if (ctrl[0]) begin
      cycle <= cycle + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl   <= 32'd1;
      tohost <= '0;
      done   <= 1'b0;
    end else if (mmio_wr) begin
      if (reg_sel == REG_CTRL) ctrl <= DM_in;
      if (reg_sel == REG_TOHOST) begin
        tohost <= DM_in;
        done   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err      <= 1'b0;
      err_seen <= 1'b0;
    end else begin
      err <= DM_enable && (dec == DEC_UNMAPPED);
      if (DM_enable && (dec == DEC_UNMAPPED)) err_seen <= 1'b1;
    end
  end

  // SRAM data stays in the SRAM's own read register; only the source is tracked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q     <= '0;
      sel_sram <= 1'b0;
    end else if (rd) begin
      sel_sram <= (dec == DEC_SRAM);
      if (dec == DEC_MMIO) rd_q <= reg_rdata;
      else if (dec == DEC_UNMAPPED) rd_q <= BAD_DATA;
    end
  end

  assign DM_out = sel_sram ? sram_rdata : rd_q;

endmodule

// File: tb/tb_dm_mmio_responder.sv
// Self-checking bench for dm_mmio_responder: address-range model
// compared every cycle plus hand-computed directed expectations.
module tb_dm_mmio_responder;

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam logic [31:0] A_CYC = 32'h1000_0000;
  localparam logic [31:0] A_CTL = 32'h1000_0004;
  localparam logic [31:0] A_TOH = 32'h1000_0008;
  localparam logic [31:0] A_STS = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        DM_enable = 1'b0;
  logic        DM_write = 1'b0;
  logic [31:0] DM_address = '0;
  logic [31:0] DM_in = '0;
  logic [31:0] DM_out;
  logic        done;
  logic [31:0] tohost;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  bit started = 1'b0;

  dm_mmio_responder dut (
    .clk       (clk),
    .rst       (rst),
    .DM_enable (DM_enable),
    .DM_write  (DM_write),
    .DM_address(DM_address),
    .DM_in     (DM_in),
    .DM_out    (DM_out),
    .done      (done),
    .tohost    (tohost),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: address ranges and plain variables.
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_out, m_tohost, m_cycle, m_ctrl, cyc_next;
  logic        m_done, m_err, m_err_seen;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out = '0; m_tohost = '0; m_cycle = '0; m_ctrl = 32'd1;
      m_done = 1'b0; m_err = 1'b0; m_err_seen = 1'b0;
    end else begin
      cyc_next = m_ctrl[0] ? m_cycle + 32'd1 : m_cycle;
      m_err = 1'b0;
      if (DM_enable) begin
        if (DM_address < 32'h0004_0000) begin
          if (DM_write) m_mem[int'(DM_address[17:2])] = DM_in;
          else m_out = m_mem[int'(DM_address[17:2])];
        end else if (DM_address >= 32'h1000_0000 &&
                     DM_address <  32'h1000_0010) begin
          case (DM_address[3:2])
            2'd0: if (DM_write) cyc_next = DM_in; else m_out = m_cycle;
            2'd1: if (DM_write) m_ctrl = DM_in; else m_out = m_ctrl;
            2'd2: if (DM_write) begin
                    m_tohost = DM_in; m_done = 1'b1;
                  end else m_out = m_tohost;
            default: if (!DM_write) m_out = {30'd0, m_err_seen, m_done};
          endcase
        end else begin
          m_err = 1'b1;
          m_err_seen = 1'b1;
          if (!DM_write) m_out = BAD;
        end
      end
      m_cycle = cyc_next;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started && rst) begin
      chk("model DM_out", DM_out, m_out);
      chk("model done", {31'd0, done}, {31'd0, m_done});
      chk("model tohost", tohost, m_tohost);
      chk("model err", {31'd0, err}, {31'd0, m_err});
    end
  end

  task automatic op(input logic w, input logic [31:0] a,
                    input logic [31:0] d);
    DM_enable = 1'b1;
    DM_write = w;
    DM_address = a;
    DM_in = d;
    @(negedge clk);
    DM_enable = 1'b0;
    DM_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    started = 1'b1;

    idle(5);
    chk("reset DM_out", DM_out, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    op(1'b0, A_CYC, '0);
    chk("cycle after 5", DM_out, 32'd5);

    op(1'b1, 32'h0000_0040, 32'h1234_5678);
    chk("write hold", DM_out, 32'd5);
    op(1'b0, 32'h0000_0040, '0);
    chk("sram rd 0x40", DM_out, 32'h1234_5678);

    op(1'b1, A_CTL, 32'd0);
    op(1'b0, A_CYC, '0);
    chk("cycle frozen a", DM_out, 32'd9);
    idle(3);
    op(1'b0, A_CYC, '0);
    chk("cycle frozen b", DM_out, 32'd9);
    op(1'b1, A_CYC, 32'hFFFF_FFFF);
    op(1'b1, A_CTL, 32'd1);
    idle(1);
    op(1'b0, A_CYC, '0);
    chk("cycle wrap", DM_out, 32'd0);

    op(1'b1, A_TOH, 32'd7);
    chk("done first", {31'd0, done}, 32'd1);
    chk("tohost 7", tohost, 32'd7);
    op(1'b1, A_TOH, 32'd9);
    chk("done sticky", {31'd0, done}, 32'd1);
    chk("tohost 9", tohost, 32'd9);
    op(1'b0, A_STS, '0);
    chk("status done", DM_out, 32'd1);
    op(1'b0, A_TOH, '0);
    chk("tohost rd", DM_out, 32'd9);

    op(1'b0, 32'h2000_0000, '0);
    chk("bad rd data", DM_out, BAD);
    chk("bad rd err", {31'd0, err}, 32'd1);
    idle(1);
    chk("err pulse end", {31'd0, err}, 32'd0);
    op(1'b0, A_STS, '0);
    chk("status err", DM_out, 32'd3);
    op(1'b1, 32'h2000_0000, 32'h0000_0055);
    chk("bad wr err", {31'd0, err}, 32'd1);
    op(1'b0, 32'h1000_0010, '0);
    op(1'b0, 32'h0004_0000, '0);
    chk("bad b2b err", {31'd0, err}, 32'd1);
    chk("bad b2b data", DM_out, BAD);
    op(1'b1, 32'h0003_FFFC, 32'hCAFE_F00D);
    op(1'b0, 32'h0003_FFFC, '0);
    chk("sram top", DM_out, 32'hCAFE_F00D);
    op(1'b0, 32'h0000_0040, '0);
    chk("sram intact", DM_out, 32'h1234_5678);

    op(1'b1, A_CTL, 32'hA5A5_0000);
    op(1'b0, A_CTL, '0);
    chk("ctrl rd", DM_out, 32'hA5A5_0000);
    DM_enable = 1'b1;
    DM_write = 1'b1;
    DM_address = A_CTL;
    DM_in = 32'h0000_0002;
    #2 rst = 1'b0;
    #1;
    chk("rst DM_out", DM_out, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst tohost", tohost, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    @(negedge clk);
    DM_enable = 1'b0;
    DM_write = 1'b0;
    rst = 1'b1;
    op(1'b0, A_CYC, '0);
    chk("rst cycle", DM_out, 32'd0);
    op(1'b0, A_CTL, '0);
    chk("rst ctrl", DM_out, 32'd1);
    op(1'b0, A_STS, '0);
    chk("rst status", DM_out, 32'd0);
    op(1'b0, 32'h0000_0040, '0);
    chk("sram kept", DM_out, 32'h1234_5678);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
